// File: rtl/toaplan_snd_mix_pkg.sv
// Shared types and helpers for the toaplan_snd_mix sound mixer.
// Holds the mixer FSM states, gain/pan encodings and the output saturation function.
package toaplan_snd_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        SAT  = 2'd2
    } snd_state_t;

    localparam logic [7:0] GAIN_UNITY = 8'h10;

    localparam logic [1:0] PAN_BOTH  = 2'b00;
    localparam logic [1:0] PAN_LEFT  = 2'b01;
    localparam logic [1:0] PAN_RIGHT = 2'b10;
    localparam logic [1:0] PAN_MUTE  = 2'b11;

    // Clamp v to the signed range of a 'width'-bit value.
    function automatic logic signed [63:0] sat_to(input logic signed [63:0] v, input int width);
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        hi = (64'sd1 <<< (width - 1)) - 64'sd1;
        lo = -hi - 64'sd1;
        if (v > hi)
            sat_to = hi;
        else if (v < lo)
            sat_to = lo;
        else
            sat_to = v;
    endfunction

endpackage

// File: rtl/toaplan_snd_mix_if.sv
// Mixer sample/control bus. The master drives CEN plus the channel inputs; the slave (mixer)
// returns the mixed stereo pair, status flags and its FSM state for observation.
interface toaplan_snd_mix_if
    import toaplan_snd_pkg::*;
#(
    parameter int NCH  = 4,
    parameter int W    = 16,
    parameter int WOUT = 16
) ();
    // CEN has no ready: a CEN seen while busy is dropped and reported on overrun;
    // sample marks the single cycle where new left/right/clip values first appear.
    logic                   CEN;
    logic [NCH*W-1:0]       ch_data;
    logic [NCH-1:0]         ch_en;
    logic [NCH*8-1:0]       gain_tgt;
    logic [NCH*2-1:0]       pan;
    logic signed [WOUT-1:0] left;
    logic signed [WOUT-1:0] right;
    logic                   sample;
    logic                   busy;
    logic                   clip_l;
    logic                   clip_r;
    logic                   peak;
    logic                   overrun;
    snd_state_t             dbg_state;

    modport master (
        output CEN, ch_data, ch_en, gain_tgt, pan,
        input  left, right, sample, busy, clip_l, clip_r, peak, overrun, dbg_state
    );

    modport slave (
        input  CEN, ch_data, ch_en, gain_tgt, pan,
        output left, right, sample, busy, clip_l, clip_r, peak, overrun, dbg_state
    );
endinterface

// File: rtl/toaplan_snd_mix_gain_ramp.sv
// One channel's current gain. With TOAPLAN_SND_MIX_RAMP_EN defined it slews one LSB per update
// toward the target; otherwise it simply loads the target on each update.
module toaplan_snd_gain_ramp
    import toaplan_snd_pkg::*;
(
    input  logic       CLK96,
    input  logic       RESET96,
    input  logic       i_upd,
    input  logic [7:0] i_tgt,
    output logic [7:0] o_gain
);
    logic [7:0] r_gain;

    always_ff @(posedge CLK96 or posedge RESET96) begin
        if (RESET96) begin
            r_gain <= GAIN_UNITY;
        end else if (i_upd) begin
`ifdef TOAPLAN_SND_MIX_RAMP_EN
            if (r_gain < i_tgt)
                r_gain <= r_gain + 8'd1;
            else if (r_gain > i_tgt)
                r_gain <= r_gain - 8'd1;
`else
            r_gain <= i_tgt;
`endif
        end
    end

    assign o_gain = r_gain;
endmodule

// File: rtl/toaplan_snd_mix.sv
// Time-multiplexed NCH-channel stereo mixer: one shared multiplier, pan routing, saturation,
// peak hold. Optional gain slewing is enabled by defining TOAPLAN_SND_MIX_RAMP_EN.
module toaplan_snd_mix
    import toaplan_snd_pkg::*;
#(
    parameter int NCH       = 4,
    parameter int W         = 16,
    parameter int WOUT      = 16,
    parameter int PEAK_HOLD = 4096
) (
    input  logic              CLK96,
    input  logic              RESET96,
    toaplan_snd_mix_if.slave  bus
);
    localparam int PW = W + 9;
    localparam int AW = W + 9 + $clog2(NCH);
    localparam int IW = (NCH > 1) ? $clog2(NCH) : 1;
    localparam int CW = $clog2(PEAK_HOLD + 1);

    snd_state_t             r_state, w_next;
    logic [IW-1:0]          r_idx;
    logic [NCH*W-1:0]       r_data;
    logic [NCH-1:0]         r_en;
    logic [NCH*2-1:0]       r_pan;
    logic signed [AW-1:0]   r_acc_l, r_acc_r;
    logic signed [WOUT-1:0] r_left, r_right;
    logic                   r_sample, r_clip_l, r_clip_r, r_overrun;
    logic [CW-1:0]          r_peak_cnt;

    logic [NCH*8-1:0]       w_gain;
    logic                   w_start, w_last, w_gain_upd, w_clip_l, w_clip_r, w_to_l, w_to_r;
    logic signed [W-1:0]    w_smp;
    logic [7:0]             w_g;
    logic [1:0]             w_pan;
    logic signed [PW-1:0]   w_prod, w_p;
    logic signed [63:0]     w_ext_l, w_ext_r, w_sat_l, w_sat_r;

    assign w_start = (r_state == IDLE) && bus.CEN;
    assign w_last  = (r_idx == IW'(NCH - 1));

`ifdef TOAPLAN_SND_MIX_RAMP_EN
    assign w_gain_upd = (r_state == SAT);
`else
    assign w_gain_upd = w_start;
`endif

    for (genvar k = 0; k < NCH; k++) begin : g_ch
        toaplan_snd_gain_ramp u_ramp (
            .CLK96   (CLK96),
            .RESET96 (RESET96),
            .i_upd   (w_gain_upd),
            .i_tgt   (bus.gain_tgt[k*8 +: 8]),
            .o_gain  (w_gain[k*8 +: 8])
        );
    end

    // Shared multiplier: gain is unsigned 4.4, so it is zero-extended before the signed multiply.
    assign w_smp  = $signed(r_data[r_idx*W +: W]);
    assign w_g    = w_gain[r_idx*8 +: 8];
    assign w_pan  = r_pan[r_idx*2 +: 2];
    assign w_prod = PW'(w_smp) * PW'($signed({1'b0, w_g}));
    assign w_p    = (r_en[r_idx] && (w_pan != PAN_MUTE)) ? w_prod : '0;
    assign w_to_l = (w_pan == PAN_BOTH) || (w_pan == PAN_LEFT);
    assign w_to_r = (w_pan == PAN_BOTH) || (w_pan == PAN_RIGHT);

    assign w_ext_l  = 64'(r_acc_l >>> 4);
    assign w_ext_r  = 64'(r_acc_r >>> 4);
    assign w_sat_l  = sat_to(w_ext_l, WOUT);
    assign w_sat_r  = sat_to(w_ext_r, WOUT);
    assign w_clip_l = (w_sat_l != w_ext_l);
    assign w_clip_r = (w_sat_r != w_ext_r);

    always_ff @(posedge CLK96 or posedge RESET96) begin
        if (RESET96)
            r_state <= IDLE;
        else
            r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            IDLE:    if (bus.CEN) w_next = ACC;
            ACC:     if (w_last) w_next = SAT;
            SAT:     w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge CLK96 or posedge RESET96) begin
        if (RESET96) begin
            r_idx      <= '0;
            r_data     <= '0;
            r_en       <= '0;
            r_pan      <= '0;
            r_acc_l    <= '0;
            r_acc_r    <= '0;
            r_left     <= '0;
            r_right    <= '0;
            r_sample   <= 1'b0;
            r_clip_l   <= 1'b0;
            r_clip_r   <= 1'b0;
            r_overrun  <= 1'b0;
            r_peak_cnt <= '0;
        end else begin
            r_sample  <= 1'b0;
            r_overrun <= bus.CEN && (r_state != IDLE);
            case (r_state)
                IDLE: if (bus.CEN) begin
                    r_data  <= bus.ch_data;
                    r_en    <= bus.ch_en;
                    r_pan   <= bus.pan;
                    r_acc_l <= '0;
                    r_acc_r <= '0;
                    r_idx   <= '0;
                end
                ACC: begin
                    if (w_to_l) r_acc_l <= r_acc_l + AW'(w_p);
                    if (w_to_r) r_acc_r <= r_acc_r + AW'(w_p);
                    if (!w_last) r_idx <= r_idx + IW'(1);
                end
                SAT: begin
                    r_left   <= WOUT'(w_sat_l);
                    r_right  <= WOUT'(w_sat_r);
                    r_clip_l <= w_clip_l;
                    r_clip_r <= w_clip_r;
                    r_sample <= 1'b1;
                end
                default: ;
            endcase
            // Clips and accepted strobes never share a cycle, so load and decrement cannot collide.
            if ((r_state == SAT) && (w_clip_l || w_clip_r))
                r_peak_cnt <= CW'(PEAK_HOLD);
            else if (w_start && (r_peak_cnt != '0))
                r_peak_cnt <= r_peak_cnt - CW'(1);
        end
    end

    assign bus.left      = r_left;
    assign bus.right     = r_right;
    assign bus.sample    = r_sample;
    assign bus.busy      = (r_state != IDLE);
    assign bus.clip_l    = r_clip_l;
    assign bus.clip_r    = r_clip_r;
    assign bus.peak      = (r_peak_cnt != '0);
    assign bus.overrun   = r_overrun;
    assign bus.dbg_state = r_state;
endmodule

// File: tb/tb_toaplan_snd_mix.sv
// Directed bench for toaplan_snd_mix (NCH=4, W=16, WOUT=16, PEAK_HOLD=8).
// Expected ramp values follow TOAPLAN_SND_MIX_RAMP_EN when the bench is built with it.
module tb_toaplan_snd_mix;
    import toaplan_snd_pkg::*;

    logic CLK96;
    logic RESET96;
    int   n_cmp = 0;
    int   n_err = 0;

    toaplan_snd_mix_if #(.NCH(4), .W(16), .WOUT(16)) bus ();

    toaplan_snd_mix #(.NCH(4), .W(16), .WOUT(16), .PEAK_HOLD(8)) dut (
        .CLK96   (CLK96),
        .RESET96 (RESET96),
        .bus     (bus)
    );

    initial CLK96 = 1'b0;
    always #5 CLK96 = ~CLK96;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input longint got, input longint exp);
        n_cmp++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic clr_all();
        bus.ch_data = '0;
        bus.ch_en   = '0;
        bus.pan     = '0;
    endtask

    task automatic set_ch(input int k, input int v, input bit en, input logic [1:0] pn);
        bus.ch_data[k*16 +: 16] = v[15:0];
        bus.ch_en[k]            = en;
        bus.pan[k*2 +: 2]       = pn;
    endtask

    // One pass: strobe CEN, optionally retarget gains once accepted, wait for the sample pulse.
    task automatic run_pass(input string tag, input logic [31:0] tgt_after);
        int cyc;
        bit seen;
        @(posedge CLK96); #1 bus.CEN = 1'b1;
        @(posedge CLK96); #1 bus.CEN = 1'b0;
        bus.gain_tgt = tgt_after;
        check({tag, "_busy"}, bus.busy, 1);
        cyc  = 0;
        seen = 1'b0;
        while (!seen && cyc < 20) begin
            @(posedge CLK96); #1;
            cyc++;
            if (bus.sample) seen = 1'b1;
        end
        check({tag, "_latency"}, cyc, 5);
        @(posedge CLK96); #1;
        check({tag, "_pulse_end"}, bus.sample, 0);
    endtask

    initial begin
        int n_smp;
        int n_ovr;
        RESET96      = 1'b1;
        bus.CEN      = 1'b0;
        bus.gain_tgt = 32'h10101010;
        clr_all();
        repeat (3) @(posedge CLK96);
        #1;
        check("rst_left", bus.left, 0);
        check("rst_right", bus.right, 0);
        check("rst_busy", bus.busy, 0);
        check("rst_sample", bus.sample, 0);
        check("rst_peak", bus.peak, 0);
        check("rst_overrun", bus.overrun, 0);
        check("rst_state", bus.dbg_state, IDLE);
        RESET96 = 1'b0;

        // Unity gain, one channel to both sides.
        set_ch(0, 1000, 1'b1, PAN_BOTH);
        run_pass("unity", 32'h10101010);
        check("unity_left", bus.left, 1000);
        check("unity_right", bus.right, 1000);
        check("unity_clip_l", bus.clip_l, 0);
        check("unity_clip_r", bus.clip_r, 0);
        check("unity_state", bus.dbg_state, IDLE);

        // Pan routing and sign; a muted and a disabled channel must add nothing.
        clr_all();
        set_ch(0, 100, 1'b1, PAN_LEFT);
        set_ch(1, -200, 1'b1, PAN_RIGHT);
        set_ch(2, 5000, 1'b1, PAN_MUTE);
        set_ch(3, 7000, 1'b0, PAN_BOTH);
        run_pass("pan", 32'h10101010);
        check("pan_left", bus.left, 100);
        check("pan_right", bus.right, -200);

        // Negative saturation.
        clr_all();
        set_ch(0, -30000, 1'b1, PAN_BOTH);
        set_ch(1, -30000, 1'b1, PAN_BOTH);
        run_pass("neg_sat", 32'h10101010);
        check("neg_sat_left", bus.left, -32768);
        check("neg_sat_clip_r", bus.clip_r, 1);

        // Positive saturation, then the peak hold decays over 8 clip-free strobes.
        set_ch(0, 30000, 1'b1, PAN_BOTH);
        set_ch(1, 30000, 1'b1, PAN_BOTH);
        run_pass("pos_sat", 32'h10101010);
        check("pos_sat_left", bus.left, 32767);
        check("pos_sat_right", bus.right, 32767);
        check("pos_sat_clip_l", bus.clip_l, 1);
        check("pos_sat_clip_r", bus.clip_r, 1);
        check("pos_sat_peak", bus.peak, 1);
        clr_all();
        set_ch(0, 100, 1'b1, PAN_BOTH);
        for (int i = 1; i <= 8; i++) begin
            run_pass($sformatf("hold%0d", i), 32'h10101010);
            check($sformatf("hold%0d_clip_l", i), bus.clip_l, 0);
            check($sformatf("hold%0d_peak", i), bus.peak, (i < 8) ? 1 : 0);
        end

        // Reset in mid-pass after a clip: everything clears and the aborted pass never pulses.
        set_ch(0, 30000, 1'b1, PAN_BOTH);
        set_ch(1, 30000, 1'b1, PAN_BOTH);
        run_pass("pre_rst", 32'h10101010);
        check("pre_rst_peak", bus.peak, 1);
        @(posedge CLK96); #1 bus.CEN = 1'b1;
        @(posedge CLK96); #1 bus.CEN = 1'b0;
        @(posedge CLK96); #1 RESET96 = 1'b1;
        #1;
        check("midrst_left", bus.left, 0);
        check("midrst_right", bus.right, 0);
        check("midrst_clip_l", bus.clip_l, 0);
        check("midrst_peak", bus.peak, 0);
        check("midrst_busy", bus.busy, 0);
        @(posedge CLK96); #1 RESET96 = 1'b0;
        n_smp = 0;
        for (int i = 0; i < 8; i++) begin
            @(posedge CLK96); #1;
            if (bus.sample) n_smp++;
        end
        check("midrst_no_sample", n_smp, 0);
        clr_all();
        set_ch(0, 1000, 1'b1, PAN_BOTH);
        run_pass("post_rst", 32'h10101010);
        check("post_rst_left", bus.left, 1000);
        check("post_rst_right", bus.right, 1000);

        // Overrun: second CEN two edges in is dropped; result comes from the first snapshot.
        set_ch(0, 500, 1'b1, PAN_BOTH);
        @(posedge CLK96); #1 bus.CEN = 1'b1;
        @(posedge CLK96); #1 bus.CEN = 1'b0;
        set_ch(0, 7000, 1'b1, PAN_BOTH);
        @(posedge CLK96); #1 bus.CEN = 1'b1;
        @(posedge CLK96); #1 bus.CEN = 1'b0;
        check("ovr_pulse", bus.overrun, 1);
        n_smp = 0;
        n_ovr = 0;
        for (int i = 0; i < 10; i++) begin
            @(posedge CLK96); #1;
            if (bus.sample) n_smp++;
            if (bus.overrun) n_ovr++;
        end
        check("ovr_one_sample", n_smp, 1);
        check("ovr_single_cycle", n_ovr, 0);
        check("ovr_left", bus.left, 500);

        // Gain ramp 0x10 -> 0x00 with a 1600 input (100 per gain LSB).
        clr_all();
        set_ch(0, 1600, 1'b1, PAN_BOTH);
        bus.gain_tgt = 32'h10101010;
        run_pass("ramp0", 32'h00000000);
        check("ramp0_left", bus.left, 1600);
`ifdef TOAPLAN_SND_MIX_RAMP_EN
        for (int k = 1; k <= 17; k++) begin
            run_pass($sformatf("ramp%0d", k), 32'h00000000);
            check($sformatf("ramp%0d_left", k), bus.left, (k < 16) ? 100 * (16 - k) : 0);
        end
        check("ramp_end_right", bus.right, 0);
`else
        for (int k = 1; k <= 2; k++) begin
            run_pass($sformatf("ramp%0d", k), 32'h00000000);
            check($sformatf("ramp%0d_left", k), bus.left, 0);
        end
        check("ramp_end_right", bus.right, 0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
